tpm_sync_monitor: RTL
=====================

# tpm_sync_monitor

Multi-channel synchronisation monitor for the neural-crypto tree parity machine (TPM) core. It is the parametrised successor to the single-pair monitor. It observes CHANNELS independent TPM A/B pairs and, per channel, counts iterations and learning steps. It declares sync after a programmable run of consecutive equal-weight iterations, flags timeouts, and optionally tracks loss of sync. It sits beside the TPM pair array and feeds the top-level status/readback logic.

## Interface
- CHANNELS, 4, number of monitored TPM pairs
- SEL_W, 2, readback select width; 2**SEL_W >= CHANNELS
- ITER_W, 64, iteration counter width
- CNT_W, 32, learning-step counter width
- SYNC_HOLD, 8, consecutive weights_eq iterations required to declare sync; >= 1
- MAX_ITER, 1000000, iteration count at which an unsynced channel times out; >= 1
- STOP_ON_SYNC, 1, 1: channel freezes once synced; 0: channel keeps counting and can desync

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; zeroes all channels and puts them in RUN
- iter_valid  in  CHANNELS  bit i: pair i finished one iteration this cycle
- tau_match  in  CHANNELS  bit i: tau_A == tau_B for that iteration (learning step); qualified by iter_valid[i]
- weights_eq  in  CHANNELS  bit i: A/B weight vectors equal after that iteration; qualified by iter_valid[i]
- sel  in  SEL_W  channel selected for readback
- synced  out  CHANNELS  per-channel state == SYNCED
- timeout  out  CHANNELS  per-channel state == TIMEOUT
- all_synced  out  1  AND of synced
- done  out  1  every channel in SYNCED or TIMEOUT
- iter_count  out  ITER_W  iterations of channel sel
- sync_count  out  CNT_W  learning steps of channel sel
- sync_iter  out  ITER_W  iter_count value at the most recent sync declaration of channel sel; 0 if never synced

## Operation
- Each channel has its own state: IDLE, RUN, SYNCED, TIMEOUT (2-bit), plus registers iter, learn, streak (width sized to hold SYNC_HOLD), and s_iter.
- Reset (rst low, async): all states go to IDLE and all registers to 0. All outputs are therefore 0.
- IDLE: ignores iter_valid. start -> RUN.
- start (any state): all channels go to RUN and iter/learn/streak/s_iter are cleared. start has priority over iter_valid in the same cycle; that iteration is dropped.
- RUN, on iter_valid[i]:
  - iter' = iter+1, saturating at 2**ITER_W-1.
  - learn' = learn+1 if tau_match[i], saturating at 2**CNT_W-1.
  - streak' = weights_eq[i] ? min(streak+1, SYNC_HOLD) : 0.
  - If streak' == SYNC_HOLD: -> SYNCED and s_iter = iter'.
  - Else if iter' >= MAX_ITER: -> TIMEOUT.
  - Sync has priority over timeout in the same iteration.
- SYNCED with STOP_ON_SYNC=1: all registers are frozen and the channel stays until start or reset.
- SYNCED with STOP_ON_SYNC=0, on iter_valid: iter and learn update as in RUN.
  - If weights_eq[i]=0: -> RUN with streak=0. s_iter is retained. The MAX_ITER check resumes from the next iteration.
  - Re-sync overwrites s_iter.
- TIMEOUT: frozen until start or reset.
- iter_valid with the channel in IDLE, TIMEOUT, or frozen SYNCED: no effect.
- Channels are fully independent. Simultaneous iter_valid on several channels is processed in the same cycle.
- Readback: iter_count, sync_count, and sync_iter combinationally select channel sel's registers. sel >= CHANNELS reads 0.

## Timing
- All state and counters update on the rising clk edge that samples iter_valid/start high. Effects are visible on outputs right after that edge, i.e. 1-cycle latency from the input cycle.
- synced/timeout are direct state decodes; all_synced/done are combinational from them, so they carry no extra delay.
- A change on sel takes effect on the readback outputs in the same cycle, with zero latency.
- rst assertion clears the block immediately, independent of clk. Deassertion is expected synchronous to clk upstream. The first start is accepted on the first edge after deassertion.
- Back-to-back iter_valid every cycle is supported at full rate.

## Test plan
- Reset, then start; channel 0 gets 8 iter_valid with weights_eq=1 and tau_match=1 on the first 5 -> synced[0] rises after the 8th edge; sel=0 reads iter_count=8, sync_count=5, sync_iter=8; other channels stay in RUN.
- weights_eq pattern 1,1,1,0 followed by 8 ones on channel 1 -> sync after the 12th iteration; sync_iter=12; the streak reset is proven.
- MAX_ITER=20 and weights_eq=0 on channel 2 -> timeout[2] after the 20th iteration; iter_count stays 20 under a further 5 iter_valid. With MAX_ITER=8 and 8 weights_eq=1, sync wins over timeout: synced=1, timeout=0.
- STOP_ON_SYNC=0: sync at iteration 8, then weights_eq=0 -> synced drops and iter_count=9; 8 more ones -> re-sync with sync_iter=17.
- All 4 channels sync or time out at different times -> done rises after the last one; all_synced=1 only if every channel synced. start then zeroes all channels and returns them to RUN. start coinciding with iter_valid -> iter_count=0 on the next cycle.
- rst pulsed low mid-count, off a clock edge -> all outputs 0 immediately; iter_valid is ignored until the next start. sel=3 with CHANNELS=3 -> readback reads 0.

Source files
------------

// File: rtl/tpm_sync_monitor.sv
// tpm_sync_monitor: watches CHANNELS independent TPM A/B pairs. For each pair it
// counts iterations and learning steps, declares sync after SYNC_HOLD
// consecutive equal-weight iterations, and flags a timeout at MAX_ITER.
// With STOP_ON_SYNC=0 a synced channel keeps counting and can lose sync.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse: clear every channel and put it in RUN
//   iter_valid[i]     pair i finished an iteration this cycle
//   tau_match[i]      that iteration was a learning step (qualified by iter_valid)
//   weights_eq[i]     A/B weights equal after that iteration (qualified by iter_valid)
//   sel               channel picked for readback
//   synced, timeout   per-channel state decodes
//   all_synced, done  every channel synced / every channel finished
//   iter_count, sync_count, sync_iter   readback of channel sel (0 if sel out of range)
module tpm_sync_monitor #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned ITER_W       = 64,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned SYNC_HOLD    = 8,
    parameter int unsigned MAX_ITER     = 1000000,
    parameter bit          STOP_ON_SYNC = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CHANNELS-1:0] iter_valid,
    input  logic [CHANNELS-1:0] tau_match,
    input  logic [CHANNELS-1:0] weights_eq,
    input  logic [SEL_W-1:0]    sel,
    output logic [CHANNELS-1:0] synced,
    output logic [CHANNELS-1:0] timeout,
    output logic                all_synced,
    output logic                done,
    output logic [ITER_W-1:0]   iter_count,
    output logic [CNT_W-1:0]    sync_count,
    output logic [ITER_W-1:0]   sync_iter
);

    localparam int unsigned STREAK_W = $clog2(SYNC_HOLD + 1);
    localparam logic [STREAK_W-1:0] HOLD_V     = STREAK_W'(SYNC_HOLD);
    localparam logic [ITER_W-1:0]   MAX_ITER_V = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SYNCED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e              state_q  [CHANNELS];
    state_e              state_d  [CHANNELS];
    logic [ITER_W-1:0]   iter_q   [CHANNELS];
    logic [ITER_W-1:0]   iter_d   [CHANNELS];
    logic [CNT_W-1:0]    learn_q  [CHANNELS];
    logic [CNT_W-1:0]    learn_d  [CHANNELS];
    logic [STREAK_W-1:0] streak_q [CHANNELS];
    logic [STREAK_W-1:0] streak_d [CHANNELS];
    logic [ITER_W-1:0]   s_iter_q [CHANNELS];
    logic [ITER_W-1:0]   s_iter_d [CHANNELS];

    // Per-channel next-state and counter update
    always_comb begin
        logic [ITER_W-1:0]   iter_inc;
        logic [CNT_W-1:0]    learn_inc;
        logic [STREAK_W-1:0] streak_nxt;
        iter_inc   = '0;
        learn_inc  = '0;
        streak_nxt = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_d[i]  = state_q[i];
            iter_d[i]   = iter_q[i];
            learn_d[i]  = learn_q[i];
            streak_d[i] = streak_q[i];
            s_iter_d[i] = s_iter_q[i];

            // Saturating increments; the streak clamps at the hold length
            iter_inc   = (iter_q[i] == '1) ? iter_q[i] : iter_q[i] + ITER_W'(1);
            learn_inc  = (tau_match[i] && (learn_q[i] != '1)) ? learn_q[i] + CNT_W'(1)
                                                              : learn_q[i];
            streak_nxt = !weights_eq[i]          ? '0 :
                         (streak_q[i] >= HOLD_V) ? HOLD_V :
                                                   streak_q[i] + STREAK_W'(1);

            if (start) begin
                // start wins over a coincident iteration, which is dropped
                state_d[i]  = ST_RUN;
                iter_d[i]   = '0;
                learn_d[i]  = '0;
                streak_d[i] = '0;
                s_iter_d[i] = '0;
            end else if (iter_valid[i]) begin
                unique case (state_q[i])
                    ST_RUN: begin
                        iter_d[i]   = iter_inc;
                        learn_d[i]  = learn_inc;
                        streak_d[i] = streak_nxt;
                        if (streak_nxt == HOLD_V) begin
                            state_d[i]  = ST_SYNCED;
                            s_iter_d[i] = iter_inc;
                        end else if (iter_inc >= MAX_ITER_V) begin
                            state_d[i] = ST_TIMEOUT;
                        end
                    end
                    ST_SYNCED: begin
                        // Free-running mode only; otherwise the channel is frozen
                        if (!STOP_ON_SYNC) begin
                            iter_d[i]  = iter_inc;
                            learn_d[i] = learn_inc;
                            if (!weights_eq[i]) begin
                                state_d[i]  = ST_RUN;
                                streak_d[i] = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]  <= ST_IDLE;
                iter_q[i]   <= '0;
                learn_q[i]  <= '0;
                streak_q[i] <= '0;
                s_iter_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]  <= state_d[i];
                iter_q[i]   <= iter_d[i];
                learn_q[i]  <= learn_d[i];
                streak_q[i] <= streak_d[i];
                s_iter_q[i] <= s_iter_d[i];
            end
        end
    end

    // State decodes
    always_comb begin
        synced  = '0;
        timeout = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            synced[i]  = (state_q[i] == ST_SYNCED);
            timeout[i] = (state_q[i] == ST_TIMEOUT);
        end
    end

    assign all_synced = &synced;
    assign done       = &(synced | timeout);

    // Readback mux; an unmatched sel leaves the outputs at zero
    always_comb begin
        iter_count = '0;
        sync_count = '0;
        sync_iter  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (sel == SEL_W'(i)) begin
                iter_count = iter_q[i];
                sync_count = learn_q[i];
                sync_iter  = s_iter_q[i];
            end
        end
    end

endmodule
